// File: rtl/segre_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : segre_pkg                                                       |
// | Purpose  : Shared types and constants for the instruction-cache refill     |
// |            path (refill FSM encoding, icache line count).                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package segre_pkg;

  // Number of icache lines tracked by the refill handler (2**index bits)
  localparam int ICACHE_NUM_LINES = 4;

  // Refill handler states
  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_REQ  = 2'd1,
    RF_WAIT = 2'd2,
    RF_FILL = 2'd3
  } ic_refill_state_e;

endpackage
`default_nettype wire

// File: rtl/segre_lru_ages.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segre_lru_ages                                                  |
// | Purpose  : True-LRU age tracker. Ages are a permutation of                 |
// |            0..NUM_LINES-1; NUM_LINES-1 is MRU, 0 is LRU. A touch makes     |
// |            the line MRU and shifts every younger line down by one.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module segre_lru_ages
  import segre_pkg::*;
#(
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int INDEX_SIZE = $clog2(NUM_LINES)
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  touch_i,
  input  logic [INDEX_SIZE-1:0] touch_index_i,
  output logic [INDEX_SIZE-1:0] lru_index_o
);

  logic [INDEX_SIZE-1:0] age_q [NUM_LINES];

  // Age update: touched line becomes MRU, lines younger than it age by one
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        age_q[i] <= INDEX_SIZE'(i);
      end
    end else if (touch_i) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (INDEX_SIZE'(i) == touch_index_i) begin
          age_q[i] <= INDEX_SIZE'(NUM_LINES - 1);
        end else if (age_q[i] > age_q[touch_index_i]) begin
          // Strictly greater than some age, so never zero: no wrap
          age_q[i] <= age_q[i] - 1'b1;
        end
      end
    end
  end

  // LRU line is the unique line whose age is zero
  always_comb begin
    lru_index_o = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (age_q[i] == '0) begin
        lru_index_o = INDEX_SIZE'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/segre_ic_refill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segre_ic_refill                                                 |
// | Purpose  : Instruction-cache miss handler. Fetches a missing line from     |
// |            main memory, picks a victim (lowest invalid line, else LRU),    |
// |            returns the line to IF with a one-cycle fill strobe, and        |
// |            tracks line validity and LRU ages.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module segre_ic_refill
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE         = 32,
  parameter int ICACHE_LANE_SIZE  = 128,
  parameter int ICACHE_INDEX_SIZE = 2,
  parameter int ICACHE_BYTE_SIZE  = 4
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         ic_access_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  input  logic                         invalidate_i,
  output logic                         mem_rd_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_ready_i,
  input  logic [ICACHE_LANE_SIZE-1:0]  mem_data_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         busy_o
);

  localparam int NUM_LINES = 2 ** ICACHE_INDEX_SIZE;

  ic_refill_state_e               state_q;
  logic [ADDR_SIZE-1:0]           miss_addr_q;
  logic [NUM_LINES-1:0]           valid_q;
  logic [NUM_LINES-1:0]           valid_d;
  logic                           touch;
  logic [ICACHE_INDEX_SIZE-1:0]   touch_index;
  logic [ICACHE_INDEX_SIZE-1:0]   lru_index;
  logic [ICACHE_INDEX_SIZE-1:0]   victim;
  logic                           unused_addr_bits;

  // Only the line-index bits of the address are used on a hit
  assign unused_addr_bits = ^ic_addr_i[ICACHE_BYTE_SIZE-1:0];

  // The read address is only presented alongside the request pulse
  assign mem_addr_o = mem_rd_o ? miss_addr_q : '0;

  // Victim: lowest-index invalid line wins, otherwise the LRU line
  always_comb begin
    victim = lru_index;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

  // Age touches: hits in IDLE, and the filled line when leaving FILL
  always_comb begin
    touch       = 1'b0;
    touch_index = ic_addr_i[ICACHE_INDEX_SIZE-1:0];
    if (state_q == RF_IDLE && ic_access_i && !ic_miss_i) begin
      touch = 1'b1;
    end else if (state_q == RF_FILL) begin
      touch       = 1'b1;
      touch_index = mmu_lru_index_o;
    end
  end

  // Next valid vector: invalidate first, then the fill sets its own line
  always_comb begin
    valid_d = invalidate_i ? '0 : valid_q;
    if (state_q == RF_FILL) begin
      valid_d[mmu_lru_index_o] = 1'b1;
    end
  end

  // Line validity register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Refill FSM with registered outputs
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q         <= RF_IDLE;
      miss_addr_q     <= '0;
      mem_rd_o        <= 1'b0;
      mmu_data_o      <= 1'b0;
      mmu_wr_data_o   <= '0;
      mmu_lru_index_o <= '0;
      busy_o          <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (ic_access_i && ic_miss_i) begin
            miss_addr_q <= {ic_addr_i[ADDR_SIZE-1:ICACHE_BYTE_SIZE],
                            {ICACHE_BYTE_SIZE{1'b0}}};
            mem_rd_o    <= 1'b1;
            busy_o      <= 1'b1;
            state_q     <= RF_REQ;
          end
        end
        RF_REQ: begin
          mem_rd_o <= 1'b0;
          state_q  <= RF_WAIT;
        end
        RF_WAIT: begin
          if (mem_ready_i) begin
            mmu_wr_data_o   <= mem_data_i;
            mmu_lru_index_o <= victim;
            mmu_data_o      <= 1'b1;
            state_q         <= RF_FILL;
          end
        end
        RF_FILL: begin
          mmu_data_o <= 1'b0;
          busy_o     <= 1'b0;
          state_q    <= RF_IDLE;
        end
        default: begin
          mem_rd_o   <= 1'b0;
          mmu_data_o <= 1'b0;
          busy_o     <= 1'b0;
          state_q    <= RF_IDLE;
        end
      endcase
    end
  end

  segre_lru_ages #(
    .NUM_LINES  (NUM_LINES),
    .INDEX_SIZE (ICACHE_INDEX_SIZE)
  ) u_lru_ages (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .touch_i       (touch),
    .touch_index_i (touch_index),
    .lru_index_o   (lru_index)
  );

endmodule
`default_nettype wire

// File: tb/tb_segre_ic_refill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_segre_ic_refill                                              |
// | Purpose  : Self-checking bench for segre_ic_refill. Reference keeps line   |
// |            validity as flags and recency as an LRU-first queue of indices. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_segre_ic_refill;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b0;
  logic         ic_access_i = 1'b0;
  logic         ic_miss_i = 1'b0;
  logic [31:0]  ic_addr_i = '0;
  logic         invalidate_i = 1'b0;
  logic         mem_rd_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_data_i = '0;
  logic         mmu_data_o;
  logic [127:0] mmu_wr_data_o;
  logic [1:0]   mmu_lru_index_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int fill_cnt = 0;

  // Reference model state
  bit m_valid [4];
  int m_order [$];   // least recently used first

  segre_ic_refill dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .ic_access_i     (ic_access_i),
    .ic_miss_i       (ic_miss_i),
    .ic_addr_i       (ic_addr_i),
    .invalidate_i    (invalidate_i),
    .mem_rd_o        (mem_rd_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_data_i      (mem_data_i),
    .mmu_data_o      (mmu_data_o),
    .mmu_wr_data_o   (mmu_wr_data_o),
    .mmu_lru_index_o (mmu_lru_index_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters for request and fill strobes
  always @(posedge clk_i) begin
    if (mem_rd_o)   rd_cnt++;
    if (mmu_data_o) fill_cnt++;
  end

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_order = '{0, 1, 2, 3};
  endfunction

  function automatic void m_touch(input int k);
    for (int j = 0; j < m_order.size(); j++) begin
      if (m_order[j] == k) begin
        m_order.delete(j);
        break;
      end
    end
    m_order.push_back(k);
  endfunction

  function automatic void m_invalidate();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return m_order[0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd"},    mem_rd_o, 0);
    chk({tag, "_addr"},  mem_addr_o, 0);
    chk({tag, "_fill"},  mmu_data_o, 0);
    chk({tag, "_data"},  mmu_wr_data_o, 0);
    chk({tag, "_index"}, mmu_lru_index_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
  endtask

  task automatic do_reset();
    #2 rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
    m_reset();
    tick();
  endtask

  // Full miss transaction; delay = cycles from request pulse to ready
  task automatic do_miss(input logic [31:0] addr, input logic [127:0] data,
                         input int delay, input bit inv_at_ready, input bit extra_miss);
    int v;
    ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = addr;
    tick();
    ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
    chk("req_pulse", mem_rd_o, 1);
    chk("req_addr", mem_addr_o, {addr[31:4], 4'h0});
    chk("req_busy", busy_o, 1);
    for (int i = 0; i < delay; i++) begin
      if (extra_miss && i == 1) begin
        ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = addr ^ 32'h100;
      end
      tick();
      ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
      chk("wait_no_rd", mem_rd_o, 0);
      chk("wait_no_fill", mmu_data_o, 0);
    end
    v = m_victim();
    mem_ready_i = 1'b1; mem_data_i = data; invalidate_i = inv_at_ready;
    tick();
    mem_ready_i = 1'b0; mem_data_i = '0; invalidate_i = 1'b0;
    if (inv_at_ready) m_invalidate();
    chk("fill_strobe", mmu_data_o, 1);
    chk("fill_index", mmu_lru_index_o, v);
    chk("fill_data", mmu_wr_data_o, data);
    tick();
    m_valid[v] = 1'b1;
    m_touch(v);
    chk("post_fill_strobe", mmu_data_o, 0);
    chk("post_fill_busy", busy_o, 0);
    chk("post_fill_index", mmu_lru_index_o, v);
    chk("post_fill_data", mmu_wr_data_o, data);
  endtask

  task automatic do_hit(input int idx);
    ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = 32'(idx);
    tick();
    ic_access_i = 1'b0; ic_addr_i = '0;
    m_touch(idx);
    chk("hit_no_rd", mem_rd_o, 0);
    chk("hit_no_busy", busy_o, 0);
  endtask

  task automatic do_inval_idle();
    invalidate_i = 1'b1;
    tick();
    invalidate_i = 1'b0;
    m_invalidate();
  endtask

  initial begin
    int r0, f0;
    m_reset();

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    rsn_i = 1'b1;
    tick();

    // Cold miss
    do_miss(32'h0000_1234, {16{8'hA5}}, 3, 1'b0, 1'b0);

    // Fill all four lines, then a fifth miss evicts the LRU line
    do_reset();
    do_miss(32'h0000_0000, 128'h1, 1, 1'b0, 1'b0);
    do_miss(32'h0000_0010, 128'h2, 2, 1'b0, 1'b0);
    do_miss(32'h0000_0020, 128'h3, 1, 1'b0, 1'b0);
    do_miss(32'h0000_0030, 128'h4, 4, 1'b0, 1'b0);
    do_miss(32'h0000_0040, 128'h5, 1, 1'b0, 1'b0);

    // Hits on lines 0 then 2, then a miss
    do_hit(0);
    do_hit(2);
    do_miss(32'h0000_0050, 128'h6, 2, 1'b0, 1'b0);

    // Spurious inputs: ready in IDLE, second miss during WAIT
    r0 = rd_cnt;
    f0 = fill_cnt;
    mem_ready_i = 1'b1; mem_data_i = 128'hDEAD;
    tick();
    mem_ready_i = 1'b0; mem_data_i = '0;
    chk("idle_ready_no_fill", mmu_data_o, 0);
    tick();
    chk("idle_ready_no_fill2", mmu_data_o, 0);
    chk("idle_ready_cnt", fill_cnt - f0, 0);
    do_miss(32'h0000_0060, 128'h7, 3, 1'b0, 1'b1);
    tick();
    chk("spurious_rd_cnt", rd_cnt - r0, 1);
    chk("spurious_fill_cnt", fill_cnt - f0, 1);

    // Invalidate while waiting with all lines valid, then a follow-up miss
    do_miss(32'h0000_0070, 128'h8, 2, 1'b1, 1'b0);
    do_miss(32'h0000_0080, 128'h9, 1, 1'b0, 1'b0);

    // Asynchronous reset while waiting on memory
    ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = 32'h0000_0090;
    tick();
    ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
    tick();
    chk("pre_reset_busy", busy_o, 1);
    #2 rsn_i = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk_i);
    #3 rsn_i = 1'b1;
    m_reset();
    f0 = fill_cnt;
    mem_ready_i = 1'b1; mem_data_i = 128'hBEEF;
    tick();
    mem_ready_i = 1'b0; mem_data_i = '0;
    tick();
    chk("late_ready_no_fill", fill_cnt - f0, 0);
    chk("late_ready_busy", busy_o, 0);
    do_miss(32'h0000_00A0, 128'hA, 1, 1'b0, 1'b0);
    do_miss(32'h0000_00B0, 128'hB, 1, 1'b0, 1'b0);
    do_miss(32'h0000_00C0, 128'hC, 1, 1'b0, 1'b0);
    do_miss(32'h0000_00D0, 128'hD, 1, 1'b0, 1'b0);
    do_miss(32'h0000_00E0, 128'hE, 1, 1'b0, 1'b0);

    // Randomized mix of hits, misses and invalidates
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_hit($urandom_range(0, 3));
      end else if (op <= 8) begin
        do_miss($urandom, {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(1, 4), ($urandom_range(0, 4) == 0), 1'b0);
      end else begin
        do_inval_idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
